comp_bin_ascii: RTL and testbench



---
 rtl/comp_bin_ascii.sv | 140 ++++++++++++++
 tb/tb_comp_bin_ascii.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/comp_bin_ascii.sv
// Sequential binary-to-ASCII converter: double-dabble an 8-bit value into three
// decimal digits, then stream them as ASCII characters over valid/ready.
module comp_bin_ascii #(
    parameter bit SUPPRESS_ZEROS = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] bin_in,
    output logic       busy,
    output logic       done,
    output logic [6:0] ascii_c,
    output logic [6:0] ascii_d,
    output logic [6:0] ascii_u,
    output logic [6:0] char_out,
    output logic       char_valid,
    input  logic       char_ready
);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        EMIT
    } state_t;

    localparam logic [1:0] PTR_HUND  = 2'd0;
    localparam logic [1:0] PTR_TENS  = 2'd1;
    localparam logic [1:0] PTR_UNITS = 2'd2;

    state_t      state;
    logic [19:0] shift_reg;
    logic [2:0]  iter_cnt;
    logic [1:0]  char_ptr;

    logic [19:0] corrected;
    logic [19:0] shifted;
    logic [3:0]  new_hund;
    logic [3:0]  new_tens;
    logic [3:0]  new_units;
    logic [1:0]  first_ptr;
    logic [6:0]  next_c;
    logic [6:0]  next_d;
    logic [6:0]  next_u;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    function automatic logic [6:0] to_ascii(input logic [3:0] nib);
        return 7'h30 + {3'b000, nib};
    endfunction

    function automatic logic [6:0] pick(input logic [1:0] ptr, input logic [6:0] c,
                                        input logic [6:0] d, input logic [6:0] u);
        case (ptr)
            PTR_HUND: return c;
            PTR_TENS: return d;
            default:  return u;
        endcase
    endfunction

    // One double-dabble step: correct every BCD nibble, then shift the whole word.
    always_comb begin
        corrected = {add3(shift_reg[19:16]), add3(shift_reg[15:12]),
                     add3(shift_reg[11:8]), shift_reg[7:0]};
        shifted   = {corrected[18:0], 1'b0};
        new_hund  = shifted[19:16];
        new_tens  = shifted[15:12];
        new_units = shifted[11:8];
        next_c    = to_ascii(new_hund);
        next_d    = to_ascii(new_tens);
        next_u    = to_ascii(new_units);
        first_ptr = PTR_HUND;
        if (SUPPRESS_ZEROS) begin
            if (new_hund != 4'd0)
                first_ptr = PTR_HUND;
            else if (new_tens != 4'd0)
                first_ptr = PTR_TENS;
            else
                first_ptr = PTR_UNITS;
        end
    end

    // The first character is loaded on the final iteration edge so char_valid rises with done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            iter_cnt   <= '0;
            char_ptr   <= PTR_HUND;
            busy       <= 1'b0;
            done       <= 1'b0;
            ascii_c    <= 7'h30;
            ascii_d    <= 7'h30;
            ascii_u    <= 7'h30;
            char_out   <= 7'h00;
            char_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg <= {12'b0, bin_in};
                        iter_cnt  <= '0;
                        busy      <= 1'b1;
                        state     <= CONV;
                    end
                end
                CONV: begin
                    shift_reg <= shifted;
                    iter_cnt  <= iter_cnt + 3'd1;
                    if (iter_cnt == 3'd7) begin
                        ascii_c    <= next_c;
                        ascii_d    <= next_d;
                        ascii_u    <= next_u;
                        done       <= 1'b1;
                        char_valid <= 1'b1;
                        char_ptr   <= first_ptr;
                        char_out   <= pick(first_ptr, next_c, next_d, next_u);
                        state      <= EMIT;
                    end
                end
                EMIT: begin
                    if (char_ready) begin
                        if (char_ptr == PTR_UNITS) begin
                            char_valid <= 1'b0;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            char_ptr <= char_ptr + 2'd1;
                            char_out <= pick(char_ptr + 2'd1, ascii_c, ascii_d, ascii_u);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_comp_bin_ascii.sv
// Bench for comp_bin_ascii: runs a zero-suppressing and a full-width instance
// side by side and compares against decimal arithmetic on the input value.
module tb_comp_bin_ascii;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] bin_in = 8'd0;
    logic       char_ready = 1'b0;

    logic       busy_s, done_s, cv_s;
    logic [6:0] ac_s, ad_s, au_s, co_s;
    logic       busy_a, done_a, cv_a;
    logic [6:0] ac_a, ad_a, au_a, co_a;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int bin;
        int c;
        int d;
        int u;
        int mode;
        bit inject;
    } vec_t;

    vec_t vecs[9];

    comp_bin_ascii #(.SUPPRESS_ZEROS(1'b1)) dut_sup (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy_s), .done(done_s), .ascii_c(ac_s), .ascii_d(ad_s), .ascii_u(au_s),
        .char_out(co_s), .char_valid(cv_s), .char_ready(char_ready)
    );

    comp_bin_ascii #(.SUPPRESS_ZEROS(1'b0)) dut_all (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy_a), .done(done_a), .ascii_c(ac_a), .ascii_d(ad_a), .ascii_u(au_a),
        .char_out(co_a), .char_valid(cv_a), .char_ready(char_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 'h%0h expected 'h%0h", name, actual, expected);
        end
    endtask

    // Expected character stream straight from the decimal digits of v.
    function automatic void model_stream(input int v, input bit sup, output int n, output int ch[3]);
        int dg[3];
        int first;
        dg[0] = v / 100;
        dg[1] = (v / 10) % 10;
        dg[2] = v % 10;
        first = 0;
        if (sup) begin
            if (dg[0] != 0) first = 0;
            else if (dg[1] != 0) first = 1;
            else first = 2;
        end
        n = 0;
        ch = '{0, 0, 0};
        for (int i = first; i < 3; i++) begin
            ch[n] = 48 + dg[i];
            n++;
        end
    endfunction

    // mode 0: ready tied high; 1: low 5 cycles then toggling; 2: random ready.
    task automatic applyStimulus(input int v, input int ec, input int ed, input int eu,
                                 input int mode, input bit inject);
        int k, edge_cnt, fall_s, fall_a, n_s, n_a, en_s, en_a, held_s, held_a;
        int got_s[8], got_a[8], exp_s[3], exp_a[3];
        bit stall_s, stall_a, done_seen;

        model_stream(v, 1'b1, en_s, exp_s);
        model_stream(v, 1'b0, en_a, exp_a);

        @(negedge clk);
        bin_in = v[7:0];
        start = 1'b1;
        char_ready = (mode == 0);
        @(posedge clk);
        #1;
        checkOutput("busy_after_start", busy_s, 1);

        k = 0;
        done_seen = 1'b0;
        while (k < 20 && !done_seen) begin
            @(negedge clk);
            start = inject;
            if (inject) bin_in = 8'd42;
            @(posedge clk);
            #1;
            k++;
            if (done_s) done_seen = 1'b1;
        end
        checkOutput("done_latency", k, 8);
        checkOutput("done_all_sync", done_a, 1);
        checkOutput("ascii_c", ac_s, ec);
        checkOutput("ascii_d", ad_s, ed);
        checkOutput("ascii_u", au_s, eu);
        checkOutput("ascii_c_all", ac_a, ec);
        checkOutput("ascii_d_all", ad_a, ed);
        checkOutput("ascii_u_all", au_a, eu);
        checkOutput("valid_at_done", cv_s, 1);

        edge_cnt = k;
        fall_s = -1;
        fall_a = -1;
        n_s = 0;
        n_a = 0;
        stall_s = 1'b0;
        stall_a = 1'b0;
        held_s = 0;
        held_a = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy_s && fall_s < 0) fall_s = edge_cnt;
            if (!busy_a && fall_a < 0) fall_a = edge_cnt;
            if (fall_s >= 0 && fall_a >= 0) break;
            start = inject && busy_s && busy_a;
            case (mode)
                0:       char_ready = 1'b1;
                1:       char_ready = (i < 5) ? 1'b0 : ((i - 5) % 2 == 0);
                default: char_ready = 1'($urandom_range(0, 1));
            endcase
            if (cv_s) begin
                if (stall_s) checkOutput("stall_hold_sup", co_s, held_s);
                if (char_ready) begin
                    if (n_s < 8) got_s[n_s] = co_s;
                    n_s++;
                    stall_s = 1'b0;
                end else begin
                    stall_s = 1'b1;
                    held_s = co_s;
                end
            end
            if (cv_a) begin
                if (stall_a) checkOutput("stall_hold_all", co_a, held_a);
                if (char_ready) begin
                    if (n_a < 8) got_a[n_a] = co_a;
                    n_a++;
                    stall_a = 1'b0;
                end else begin
                    stall_a = 1'b1;
                    held_a = co_a;
                end
            end
            @(posedge clk);
            #1;
            edge_cnt++;
            if (i == 0) checkOutput("done_one_cycle", done_s, 0);
        end
        start = 1'b0;
        if (fall_s < 0 || fall_a < 0) checkOutput("stream_timeout", 1, 0);

        checkOutput("stream_len_sup", n_s, en_s);
        for (int j = 0; j < en_s && j < n_s; j++) checkOutput("stream_char_sup", got_s[j], exp_s[j]);
        checkOutput("stream_len_all", n_a, en_a);
        for (int j = 0; j < en_a && j < n_a; j++) checkOutput("stream_char_all", got_a[j], exp_a[j]);
        if (mode == 0) begin
            checkOutput("busy_fall_sup", fall_s, 8 + en_s);
            checkOutput("busy_fall_all", fall_a, 11);
        end
        if (inject) begin
            repeat (3) @(negedge clk);
            checkOutput("ignored_start_busy", busy_s, 0);
            checkOutput("ignored_start_c", ac_s, ec);
            checkOutput("ignored_start_d", ad_s, ed);
            checkOutput("ignored_start_u", au_s, eu);
        end
    endtask

    initial begin
        int v;
        bit done_seen;

        vecs[0] = '{198, 'h31, 'h39, 'h38, 0, 1'b0};
        vecs[1] = '{0,   'h30, 'h30, 'h30, 0, 1'b0};
        vecs[2] = '{7,   'h30, 'h30, 'h37, 0, 1'b0};
        vecs[3] = '{255, 'h32, 'h35, 'h35, 1, 1'b0};
        vecs[4] = '{105, 'h31, 'h30, 'h35, 0, 1'b1};
        vecs[5] = '{9,   'h30, 'h30, 'h39, 0, 1'b0};
        vecs[6] = '{10,  'h30, 'h31, 'h30, 0, 1'b0};
        vecs[7] = '{100, 'h31, 'h30, 'h30, 1, 1'b0};
        vecs[8] = '{99,  'h30, 'h39, 'h39, 2, 1'b0};

        repeat (2) @(negedge clk);
        checkOutput("reset_busy", busy_s, 0);
        checkOutput("reset_done", done_s, 0);
        checkOutput("reset_valid", cv_s, 0);
        checkOutput("reset_char", co_s, 0);
        checkOutput("reset_c", ac_s, 'h30);
        checkOutput("reset_d", ad_s, 'h30);
        checkOutput("reset_u", au_s, 'h30);
        rst = 1'b0;

        for (int i = 0; i < 9; i++)
            applyStimulus(vecs[i].bin, vecs[i].c, vecs[i].d, vecs[i].u, vecs[i].mode, vecs[i].inject);

        // Reset during EMIT after the first character has gone out.
        @(negedge clk);
        bin_in = 8'd198;
        start = 1'b1;
        char_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 20 && !done_seen; i++) begin
            @(posedge clk);
            #1;
            if (done_s) done_seen = 1'b1;
        end
        checkOutput("rst_seq_done", done_seen, 1);
        @(negedge clk);
        char_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_seq_second_char", co_s, 'h39);
        @(negedge clk);
        char_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_valid", cv_s, 0);
        checkOutput("rst_mid_busy", busy_s, 0);
        checkOutput("rst_mid_done", done_s, 0);
        checkOutput("rst_mid_char", co_s, 0);
        checkOutput("rst_mid_c", ac_s, 'h30);
        checkOutput("rst_mid_d", ad_s, 'h30);
        checkOutput("rst_mid_u", au_s, 'h30);
        checkOutput("rst_mid_valid_all", cv_a, 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(64, 'h30, 'h36, 'h34, 0, 1'b0);

        for (int r = 0; r < 20; r++) begin
            v = int'($urandom_range(0, 255));
            applyStimulus(v, 48 + v / 100, 48 + (v / 10) % 10, 48 + v % 10, 2, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
